// File: rtl/z80_block_search_engine.sv
// z80_block_search_engine
// Multi-cycle execution unit for the Z80 block-compare instructions CPI,
// CPD, CPIR and CPDR. Each iteration reads the byte at HL, compares it with
// A, steps HL, decrements BC and builds the flag byte. The repeating forms
// iterate until BC reaches zero, a byte matches, or an interrupt request
// makes the instruction yield between iterations.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   start                        begin an operation (only looked at in IDLE)
//   mode_dec, mode_repeat        HL direction, repeating form
//   a_in, hl_in, bc_in, f_in     architectural register values at start
//   int_req                      pending interrupt, yields a repeat form
//   mem_req, mem_addr            read request / address (held until ack)
//   mem_ack, mem_rdata           read data valid / read data
//   busy                         high in READ and COMPUTE
//   done                         one-cycle completion pulse
//   hl_out, bc_out, f_out        final register values, held until next start
//   repeat_pending               with done: instruction yielded, re-execute
//   iter_count                   iterations performed in this operation
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; results of the last operation on outputs
// READ    | memory request at HL, waiting for mem_ack
// COMPUTE | compare A with fetched byte, step HL/BC, decide next step
// DONE    | one-cycle done pulse, then back to IDLE
module z80_block_search_engine #(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 16,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode_dec,
  input  logic               mode_repeat,
  input  logic [DATA_W-1:0]  a_in,
  input  logic [ADDR_W-1:0]  hl_in,
  input  logic [COUNT_W-1:0] bc_in,
  input  logic [7:0]         f_in,
  input  logic               int_req,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  hl_out,
  output logic [COUNT_W-1:0] bc_out,
  output logic [7:0]         f_out,
  output logic               repeat_pending,
  output logic [COUNT_W:0]   iter_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]  ADDR_ONE  = 1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = 1;
  localparam logic [COUNT_W:0]   ITER_ONE  = 1;

  state_t state_q, state_d;

  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  data_q;
  logic [ADDR_W-1:0]  hl_q;
  logic [COUNT_W-1:0] bc_q;
  logic [7:0]         f_q;
  logic               dec_q;
  logic               rep_q;

  logic [DATA_W-1:0]  diff;
  logic [ADDR_W-1:0]  hl_next;
  logic [COUNT_W-1:0] bc_next;
  logic               flag_s, flag_z, flag_h, flag_pv;
  logic [7:0]         flags_next;
  logic               keep_going;
  logic               yield;

  // Only bits 5, 3 and C of the incoming flags survive into the result.
  logic unused_f_bits;
  assign unused_f_bits = ^{f_q[7:6], f_q[4], f_q[2:1]};

  // Compare datapath, only consumed in COMPUTE.
  assign diff       = a_q - data_q;
  assign flag_s     = diff[7];
  assign flag_z     = (diff == '0);
  assign flag_h     = (a_q[3:0] < data_q[3:0]);
  assign bc_next    = bc_q - COUNT_ONE;
  assign flag_pv    = (bc_next != '0);
  assign hl_next    = dec_q ? (hl_q - ADDR_ONE) : (hl_q + ADDR_ONE);
  assign flags_next = {flag_s, flag_z, f_q[5], flag_h, f_q[3], flag_pv, 1'b1, f_q[0]};

  // Count exhaustion or a match end the instruction even with int_req high;
  // only an otherwise-continuing repeat can be interrupted.
  assign keep_going = rep_q && flag_pv && !flag_z && !int_req;
  assign yield      = rep_q && flag_pv && !flag_z && int_req;

  assign mem_req  = (state_q == READ);
  assign mem_addr = hl_q;
  assign busy     = (state_q == READ) || (state_q == COMPUTE);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (mem_ack) state_d = COMPUTE;
      COMPUTE: state_d = keep_going ? READ : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q            <= '0;
      data_q         <= '0;
      hl_q           <= '0;
      bc_q           <= '0;
      f_q            <= '0;
      dec_q          <= 1'b0;
      rep_q          <= 1'b0;
      hl_out         <= '0;
      bc_out         <= '0;
      f_out          <= '0;
      repeat_pending <= 1'b0;
      iter_count     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q            <= a_in;
            hl_q           <= hl_in;
            bc_q           <= bc_in;
            f_q            <= f_in;
            dec_q          <= mode_dec;
            rep_q          <= mode_repeat;
            iter_count     <= '0;
            repeat_pending <= 1'b0;
          end
        end
        READ: begin
          if (mem_ack) data_q <= mem_rdata;
        end
        COMPUTE: begin
          hl_q           <= hl_next;
          bc_q           <= bc_next;
          hl_out         <= hl_next;
          bc_out         <= bc_next;
          f_out          <= flags_next;
          repeat_pending <= yield;
          iter_count     <= iter_count + ITER_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_block_search_engine.sv
module tb_z80_block_search_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_dec = 1'b0;
  logic        mode_repeat = 1'b0;
  logic [7:0]  a_in = '0;
  logic [15:0] hl_in = '0;
  logic [15:0] bc_in = '0;
  logic [7:0]  f_in = '0;
  logic        int_req = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        busy;
  logic        done;
  logic [15:0] hl_out;
  logic [15:0] bc_out;
  logic [7:0]  f_out;
  logic        repeat_pending;
  logic [16:0] iter_count;

  z80_block_search_engine #(.ADDR_W(16), .COUNT_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_dec(mode_dec),
    .mode_repeat(mode_repeat), .a_in(a_in), .hl_in(hl_in), .bc_in(bc_in),
    .f_in(f_in), .int_req(int_req), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .hl_out(hl_out), .bc_out(bc_out), .f_out(f_out),
    .repeat_pending(repeat_pending), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference flag byte {S,Z,5,H,3,PV,N,C} for one compare step.
  function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] d,
                                       input logic [7:0] f, input logic [15:0] bcn);
    logic [7:0] df;
    df = a - d;
    return {df[7], (df == 8'h00), f[5], (a[3:0] < d[3:0]), f[3], (bcn != 16'h0000), 1'b1, f[0]};
  endfunction

  // Memory model with a programmable number of wait cycles per read.
  logic [7:0]  mem [0:65535];
  int          wait_n = 0;
  int          wcnt = 0;
  logic [15:0] held_addr = '0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt > 0) chk("mem_addr_stable", 32'(mem_addr), 32'(held_addr));
      else held_addr <= mem_addr;
      if (wcnt < wait_n) begin
        wcnt    <= wcnt + 1;
        mem_ack <= 1'b0;
      end else begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr];
      end
    end else begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end
  end

  // Scoreboard: expectations pushed when an operation is started.
  typedef struct {
    string       tag;
    logic [15:0] hl;
    logic [15:0] bc;
    logic [7:0]  f;
    logic        rp;
    logic [16:0] it;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_hl"}, 32'(hl_out), 32'(e.hl));
        chk({e.tag, "_bc"}, 32'(bc_out), 32'(e.bc));
        chk({e.tag, "_f"}, 32'(f_out), 32'(e.f));
        chk({e.tag, "_rp"}, 32'(repeat_pending), 32'(e.rp));
        chk({e.tag, "_iter"}, 32'(iter_count), 32'(e.it));
        chk({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic run_op(input string tag, input logic dec, input logic rep,
                        input logic [7:0] a, input logic [15:0] hl, input logic [15:0] bc,
                        input logic [7:0] f, input int int_at, input logic hold,
                        input int exp_lat, input logic [15:0] e_hl, input logic [15:0] e_bc,
                        input logic [7:0] e_f, input logic e_rp, input logic [16:0] e_it);
    exp_t e;
    int   k;
    logic seen;
    e.tag = tag; e.hl = e_hl; e.bc = e_bc; e.f = e_f; e.rp = e_rp; e.it = e_it;
    @(negedge clk);
    mode_dec = dec; mode_repeat = rep; a_in = a; hl_in = hl; bc_in = bc; f_in = f;
    start = 1'b1;
    sbq.push_back(e);
    k = 0;
    seen = 1'b0;
    while (k < 2000 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (!hold) start = 1'b0;
        else begin
          // Changing inputs while busy must not disturb the running operation.
          a_in = ~a; hl_in = ~hl; bc_in = ~bc;
        end
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(hl));
      end
      if (int_at != 0 && k == int_at) int_req = 1'b1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    int_req = 1'b0;
    if (!seen) sbq.delete();
    if (hold) begin
      // start was still high on the edge leaving DONE; it must be ignored.
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_in_done_busy"}, 32'(busy), 32'd0);
      chk({tag, "_start_in_done_req"}, 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1000] = 8'h42;
    mem[16'h2000] = 8'h01;
    mem[16'h2001] = 8'h02;
    mem[16'h2002] = 8'h07;
    mem[16'h4000] = 8'h01;
    mem[16'h4001] = 8'h01;
    for (int i = 0; i < 8; i++) mem[16'h5000 + i] = 8'h11;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_hl", 32'(hl_out), 32'd0);
    chk("rst_bc", 32'(bc_out), 32'd0);
    chk("rst_f", 32'(f_out), 32'd0);
    chk("rst_rp", 32'(repeat_pending), 32'd0);
    chk("rst_iter", 32'(iter_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("cpi_match", 1'b0, 1'b0, 8'h42, 16'h1000, 16'h0003, 8'h29, 0, 1'b0, 3,
           16'h1001, 16'h0002, 8'h6F, 1'b0, 17'd1);
    repeat (3) @(negedge clk);
    chk("cpi_hold_hl", 32'(hl_out), 32'h1001);
    chk("cpi_hold_f", 32'(f_out), 32'h6F);

    run_op("cpir_match", 1'b0, 1'b1, 8'h07, 16'h2000, 16'h0005, 8'h00, 0, 1'b1, 7,
           16'h2003, 16'h0002, ref_f(8'h07, 8'h07, 8'h00, 16'h0002), 1'b0, 17'd3);

    run_op("cpdr_nomatch", 1'b1, 1'b1, 8'hFF, 16'h0001, 16'h0003, 8'hFF, 0, 1'b1, 7,
           16'hFFFE, 16'h0000, ref_f(8'hFF, 8'h00, 8'hFF, 16'h0000), 1'b0, 17'd3);

    run_op("cpir_int", 1'b0, 1'b1, 8'h55, 16'h3000, 16'h0004, 8'h00, 3, 1'b0, 5,
           16'h3002, 16'h0002, ref_f(8'h55, 8'h00, 8'h00, 16'h0002), 1'b1, 17'd2);
    run_op("cpir_resume", 1'b0, 1'b1, 8'h55, 16'h3002, 16'h0002, 8'h00, 0, 1'b0, 5,
           16'h3004, 16'h0000, ref_f(8'h55, 8'h00, 8'h00, 16'h0000), 1'b0, 17'd2);

    wait_n = 3;
    run_op("cpi_h_wait", 1'b0, 1'b0, 8'h10, 16'h4000, 16'h0001, 8'h00, 0, 1'b0, 6,
           16'h4001, 16'h0000, 8'h12, 1'b0, 17'd1);
    wait_n = 0;
    run_op("cpi_neg_bc0", 1'b0, 1'b0, 8'h00, 16'h4001, 16'h0000, 8'h00, 0, 1'b0, 3,
           16'h4002, 16'hFFFF, 8'h96, 1'b0, 17'd1);
    run_op("cpi_hl_wrap", 1'b0, 1'b0, 8'h00, 16'hFFFF, 16'h0002, 8'h28, 0, 1'b0, 3,
           16'h0000, 16'h0001, ref_f(8'h00, 8'h00, 8'h28, 16'h0001), 1'b0, 17'd1);

    // Reset in the middle of a CPIR: everything clears, no done pulse.
    @(negedge clk);
    mode_dec = 1'b0; mode_repeat = 1'b1; a_in = 8'h99; hl_in = 16'h5000;
    bc_in = 16'h0005; f_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_hl", 32'(hl_out), 32'd0);
    chk("mid_rst_bc", 32'(bc_out), 32'd0);
    chk("mid_rst_f", 32'(f_out), 32'd0);
    chk("mid_rst_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    run_op("cpi_after_rst", 1'b0, 1'b0, 8'h42, 16'h1000, 16'h0003, 8'h29, 0, 1'b0, 3,
           16'h1001, 16'h0002, 8'h6F, 1'b0, 17'd1);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
